// File: rtl/matrix_window_scheduler.sv
// Frame/line sequencer for the 3x3 matrix datapath on cmos_pclk.
// Tracks vsync/href, drives line-buffer column address, write enable and
// 3-line rotation select, and emits a registered window-valid strobe with
// the window-centre coordinates.
// Optional feature macro: WIN_BORDER_FLAG_EN (drives win_border edge flags).
module matrix_window_scheduler #(
  parameter int unsigned IMG_HDISP   = 16,
  parameter int unsigned IMG_VDISP   = 4,
  parameter logic        VSYNC_VALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  output logic       lb_wr_en,
  output logic [9:0] lb_addr,
  output logic [1:0] lb_line_sel,
  output logic       win_valid,
  output logic [9:0] win_row,
  output logic [9:0] win_col,
  output logic       frame_start,
  output logic       frame_done,
  output logic       err_hlen,
  output logic       err_vlen,
  output logic [3:0] win_border
);

  localparam int unsigned AW = 10;
  localparam logic [AW-1:0] HMAX  = AW'(IMG_HDISP);
  localparam logic [AW-1:0] VLAST = AW'(IMG_VDISP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE_WAIT,
    S_ACTIVE,
    S_FRAME_END
  } state_t;

  state_t        state_q, state_d;
  logic          vs_q, vs_qq, hr_q, hr_qq;
  logic [AW-1:0] row_q, row_d, col_q, col_d, addr_q, addr_d;
  logic [1:0]    sel_q, sel_d;
  logic          wr_en_q, wr_en_d;
  logic          fstart_q, fstart_d, fdone_q, fdone_d;
  logic          err_h_q, err_h_d, err_v_q, err_v_d;
  logic          win_valid_q;
  logic [AW-1:0] win_row_q, win_col_q;
  logic          vs_ok, vs_rise, hr_fall;
  logic          win_hit;
  logic [AW-1:0] wrow, wcol;

  assign vs_ok   = (vs_q == VSYNC_VALID);
  assign vs_rise = vs_ok && (vs_qq != VSYNC_VALID);
  assign hr_fall = hr_qq && !hr_q;

  // Input synchronisation; vsync history resets to the valid level so a frame
  // already in progress at reset release is never mistaken for a new edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q  <= VSYNC_VALID;
      vs_qq <= VSYNC_VALID;
      hr_q  <= 1'b0;
      hr_qq <= 1'b0;
    end else begin
      vs_q  <= per_frame_vsync;
      vs_qq <= vs_q;
      hr_q  <= per_frame_href;
      hr_qq <= hr_q;
    end
  end

  // State and sequencing registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      sel_q    <= '0;
      wr_en_q  <= 1'b0;
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      err_h_q  <= 1'b0;
      err_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wr_en_q  <= wr_en_d;
      fstart_q <= fstart_d;
      fdone_q  <= fdone_d;
      err_h_q  <= err_h_d;
      err_v_q  <= err_v_d;
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wr_en_d  = 1'b0;
    fstart_d = 1'b0;
    fdone_d  = 1'b0;
    err_h_d  = err_h_q;
    err_v_d  = err_v_q;
    unique case (state_q)
      S_IDLE: begin
        if (vs_rise) begin
          state_d  = S_LINE_WAIT;
          fstart_d = 1'b1;
          row_d    = '0;
          col_d    = '0;
          sel_d    = '0;
          err_h_d  = 1'b0;
          err_v_d  = 1'b0;
        end
      end
      S_LINE_WAIT, S_ACTIVE: begin
        if (!vs_ok) begin
          state_d = S_IDLE;
        end else if (hr_q) begin
          state_d = S_ACTIVE;
          if (col_q < HMAX) begin
            wr_en_d = 1'b1;
            addr_d  = col_q;
            col_d   = AW'(col_q + AW'(1));
          end else begin
            err_h_d = 1'b1;
          end
        end else if ((state_q == S_ACTIVE) && hr_fall) begin
          if (col_q != HMAX) err_h_d = 1'b1;
          col_d = '0;
          row_d = AW'(row_q + AW'(1));
          sel_d = (sel_q == 2'd2) ? 2'd0 : 2'(sel_q + 2'd1);
          if (AW'(row_q + AW'(1)) == VLAST) begin
            state_d = S_FRAME_END;
            fdone_d = 1'b1;
          end else begin
            state_d = S_LINE_WAIT;
          end
        end
      end
      S_FRAME_END: begin
        if (!vs_ok) state_d = S_IDLE;
        else if (hr_q) err_v_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A write completes a window once two earlier rows and columns exist.
  assign win_hit = wr_en_q && (row_q >= AW'(2)) && (addr_q >= AW'(2));
  assign wrow    = AW'(row_q - AW'(1));
  assign wcol    = AW'(addr_q - AW'(1));

  // Window strobe stage, one cycle behind the line-buffer write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      win_valid_q <= win_hit;
      if (win_hit) begin
        win_row_q <= wrow;
        win_col_q <= wcol;
      end
    end
  end

`ifdef WIN_BORDER_FLAG_EN
  logic [3:0] border_q;

  // Edge flags for the window centre, aligned with win_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      border_q <= '0;
    end else if (win_hit) begin
      border_q <= {wrow == AW'(1), wrow == AW'(IMG_VDISP - 2),
                   wcol == AW'(1), wcol == AW'(IMG_HDISP - 2)};
    end
  end

  assign win_border = border_q;
`else
  assign win_border = 4'b0000;
`endif

  assign lb_wr_en    = wr_en_q;
  assign lb_addr     = addr_q;
  assign lb_line_sel = sel_q;
  assign win_valid   = win_valid_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign err_hlen    = err_h_q;
  assign err_vlen    = err_v_q;

endmodule

// File: tb/tb_matrix_window_scheduler.sv
// Self-checking bench for matrix_window_scheduler (IMG_HDISP=16, IMG_VDISP=4).
// Frames are described as line lengths; an event-level model predicts the
// write list, window list, frame_done count and sticky error flags.
module tb_matrix_window_scheduler;

  localparam int H = 16;
  localparam int V = 4;

  typedef int lens_t[5];
  typedef struct {
    int    nl;
    lens_t l;
    int    exp_w;
    int    exp_win;
    int    exp_h;
    int    exp_v;
    int    exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, vs, hr;
  logic       lb_wr_en, win_valid, frame_start, frame_done, err_hlen, err_vlen;
  logic [9:0] lb_addr, win_row, win_col;
  logic [1:0] lb_line_sel;
  logic [3:0] win_border;

  matrix_window_scheduler #(.IMG_HDISP(H), .IMG_VDISP(V), .VSYNC_VALID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hr),
    .lb_wr_en(lb_wr_en), .lb_addr(lb_addr), .lb_line_sel(lb_line_sel),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .frame_start(frame_start), .frame_done(frame_done),
    .err_hlen(err_hlen), .err_vlen(err_vlen), .win_border(win_border)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wq[$], winq[$], exp_w[$], exp_win[$];
  int fs_cnt, fd_cnt, exp_h, exp_v, exp_done;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmpq(input string name, input int act[$], input int exp[$]);
    int bad = -1;
    checks++;
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      if (bad < 0 && act[i] != exp[i]) bad = i;
    if (act.size() != exp.size() || bad >= 0) begin
      errors++;
      $display("FAIL %s: got %0d entries expected %0d, first differing index %0d (got 0x%0h expected 0x%0h)",
               name, act.size(), exp.size(), bad,
               (bad >= 0) ? act[bad] : 0, (bad >= 0) ? exp[bad] : 0);
    end
  endtask

  // Record observable events away from the clock edge.
  task automatic sample();
    if (lb_wr_en) wq.push_back(int'(lb_line_sel) * 1024 + int'(lb_addr));
    if (win_valid) winq.push_back((int'(win_row) * 1024 + int'(win_col)) * 16 + int'(win_border));
    if (frame_start) fs_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic cyc(input logic v, input logic h);
    vs = v;
    hr = h;
    @(posedge clk);
    #1;
    sample();
  endtask

  function automatic int border(input int r, input int c);
`ifdef WIN_BORDER_FLAG_EN
    return ((r == 1) ? 8 : 0) + ((r == V - 2) ? 4 : 0) + ((c == 1) ? 2 : 0) + ((c == H - 2) ? 1 : 0);
`else
    return r * 0 + c * 0;
`endif
  endfunction

  // Expected events derived directly from the line lengths of one frame.
  task automatic model(input int nl, input lens_t l);
    exp_w.delete();
    exp_win.delete();
    exp_h = 0;
    exp_v = 0;
    exp_done = (nl >= V) ? 1 : 0;
    for (int i = 0; i < nl; i++) begin
      if (i < V) begin
        int n = (l[i] < H) ? l[i] : H;
        for (int c = 0; c < n; c++) exp_w.push_back((i % 3) * 1024 + c);
        if (i >= 2)
          for (int c = 2; c < n; c++)
            exp_win.push_back(((i - 1) * 1024 + (c - 1)) * 16 + border(i - 1, c - 1));
        if (l[i] != H) exp_h = 1;
      end else if (l[i] > 0) begin
        exp_v = 1;
      end
    end
  endtask

  task automatic run_frame(input int nl, input lens_t l, input int gap, input string tag);
    wq.delete();
    winq.delete();
    fs_cnt = 0;
    fd_cnt = 0;
    repeat (3) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    chk({tag, "_fstart"}, fs_cnt, 1);
    chk({tag, "_err_cleared"}, int'(err_hlen) + int'(err_vlen), 0);
    for (int i = 0; i < nl; i++) begin
      repeat (l[i]) cyc(1'b1, 1'b1);
      repeat (gap) cyc(1'b1, 1'b0);
    end
    repeat (3) cyc(1'b1, 1'b0);
    model(nl, l);
    cmpq({tag, "_writes"}, wq, exp_w);
    cmpq({tag, "_windows"}, winq, exp_win);
    chk({tag, "_fdone"}, fd_cnt, exp_done);
    chk({tag, "_err_hlen"}, int'(err_hlen), exp_h);
    chk({tag, "_err_vlen"}, int'(err_vlen), exp_v);
  endtask

  task automatic set_vec(input int idx, input int nl, input int l0, input int l1, input int l2,
                         input int l3, input int l4, input int ew, input int ewin,
                         input int eh, input int ev, input int ed);
    tbl[idx].nl = nl;
    tbl[idx].l[0] = l0; tbl[idx].l[1] = l1; tbl[idx].l[2] = l2;
    tbl[idx].l[3] = l3; tbl[idx].l[4] = l4;
    tbl[idx].exp_w = ew;
    tbl[idx].exp_win = ewin;
    tbl[idx].exp_h = eh;
    tbl[idx].exp_v = ev;
    tbl[idx].exp_done = ed;
  endtask

  initial begin
    lens_t rl;
    string tag;
    set_vec(0, 4, 16, 16, 16, 16, 0, 64, 28, 0, 0, 1);  // nominal
    set_vec(1, 4, 16, 18, 16, 16, 0, 64, 28, 1, 0, 1);  // long line 1
    set_vec(2, 5, 16, 16, 16, 16, 16, 64, 28, 0, 1, 1); // extra line after done
    set_vec(3, 4, 16, 16, 10, 16, 0, 58, 22, 1, 0, 1);  // short line 2
    set_vec(4, 4, 16, 16, 16, 18, 0, 64, 28, 1, 0, 1);  // long last line
    set_vec(5, 3, 16, 16, 16, 0, 0, 48, 14, 0, 0, 0);   // vsync drops early

    rst_n = 1'b0;
    vs = 1'b0;
    hr = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    chk("reset_outputs", int'(|{lb_wr_en, lb_addr, lb_line_sel, win_valid, win_row, win_col,
                               frame_start, frame_done, err_hlen, err_vlen, win_border}), 0);

    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      run_frame(tbl[i].nl, tbl[i].l, 3, tag);
      chk({tag, "_nwr"}, wq.size(), tbl[i].exp_w);
      chk({tag, "_nwin"}, winq.size(), tbl[i].exp_win);
      chk({tag, "_tbl_h"}, int'(err_hlen), tbl[i].exp_h);
      chk({tag, "_tbl_v"}, int'(err_vlen), tbl[i].exp_v);
      chk({tag, "_tbl_done"}, fd_cnt, tbl[i].exp_done);
    end

    // Write latency, then a one-cycle reset in the middle of line 2.
    wq.delete();
    fs_cnt = 0;
    repeat (3) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("lat_first_edge", int'(lb_wr_en), 0);
    cyc(1'b1, 1'b1);
    chk("lat_wr_en", int'(lb_wr_en), 1);
    chk("lat_addr", int'(lb_addr), 0);
    chk("lat_sel", int'(lb_line_sel), 0);
    repeat (14) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    repeat (16) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b1);
    chk("pre_rst_sel", int'(lb_line_sel), 2);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1);
    rst_n = 1'b1;
    chk("midrst_outputs", int'(|{lb_wr_en, lb_addr, lb_line_sel, win_valid, win_row, win_col,
                                frame_start, frame_done, err_hlen, err_vlen, win_border}), 0);
    wq.delete();
    winq.delete();
    fs_cnt = 0;
    fd_cnt = 0;
    repeat (11) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    repeat (16) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    chk("postrst_writes", wq.size(), 0);
    chk("postrst_windows", winq.size(), 0);
    chk("postrst_fstart", fs_cnt, 0);
    chk("postrst_fdone", fd_cnt, 0);
    run_frame(tbl[0].nl, tbl[0].l, 2, "after_rst");

    // Randomised frames against the model.
    for (int f = 0; f < 25; f++) begin
      int nl = $urandom_range(3, 5);
      for (int i = 0; i < 5; i++)
        rl[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 19) : H;
      run_frame(nl, rl, $urandom_range(2, 5), $sformatf("rnd%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
